fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Instruction-fetch stage directly upstream of ID; produces the instruction word and PC+4 that ID decodes.
- Owns the PC and drives a multi-cycle instruction-memory request/ready port.
- Honours ID hazard freeze and EXE branch redirect.
- Contains a one-entry output register (IF/ID slot) plus a one-entry skid buffer, so a memory response is never lost while ID is frozen.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
PC_STEP, 4, byte increment between sequential fetches.

Ports:
clk  in  1  clock; all state on rising edge.
rst  in  1  asynchronous, active-low reset.
freeze  in  1  hazard stall from ID; holds the output slot.
branch_taken  in  1  redirect from EXE, one-cycle pulse.
branch_addr  in  32  redirect target byte address.
imem_req  out  1  fetch request; held until imem_ready.
imem_addr  out  32  fetch address; stable while imem_req=1.
imem_ready  in  1  memory response strobe; imem_rdata valid this cycle only.
imem_rdata  in  32  fetched instruction word.
inst_valid  out  1  output slot holds a live instruction.
instruction  out  32  instruction to ID.
pc_out  out  32  fetch address + PC_STEP of that instruction.

Behaviour:
- Reset (rst=0, async): pc=RESET_PC, req_addr=RESET_PC, state=S_IDLE, skid empty. Outputs: imem_req=0, inst_valid=0, instruction=0, pc_out=0.
- State encodings:
  - S_IDLE: imem_req=0.
  - S_REQ: imem_req=1.
  - S_SQUASH: imem_req=1; response will be discarded.
  - S_HOLD: imem_req=0; skid full.
- imem_addr=req_addr in all states. req_addr<=pc on every entry to S_REQ.
- slot_free = !inst_valid || !freeze. A consume occurs when inst_valid=1 and freeze=0.
- Output slot update when nothing new loads: a consume clears inst_valid next cycle; if freeze=1, the slot holds all values.
- S_IDLE -> S_REQ unconditionally (first request is the 2nd cycle after reset release).
- S_REQ transitions:
  - imem_ready & branch_taken: data dropped; pc<=branch_addr; stay S_REQ.
  - imem_ready & slot_free: slot<= {rdata, req_addr+PC_STEP}, inst_valid<=1; pc<=pc+PC_STEP; stay S_REQ.
  - imem_ready & !slot_free: skid<=response; pc+=PC_STEP; go S_HOLD.
  - !imem_ready & branch_taken: pc<=branch_addr; go S_SQUASH, req_addr unchanged.
  - otherwise stay.
- S_SQUASH:
  - Requests are never withdrawn; stays until imem_ready, then discards data and goes S_REQ.
  - A further branch_taken while in S_SQUASH overwrites pc.
- S_HOLD:
  - branch_taken: skid discarded, pc<=branch_addr, go S_REQ.
  - Consume this cycle: slot<=skid, inst_valid<=1, go S_REQ.
- branch_taken in any state: inst_valid<=0 next cycle. Branch wins over freeze and over a same-cycle response.
- Back-to-back throughput: one instruction per memory response. With a zero-wait memory (ready in the request cycle), sustains 1 instr/cycle.
- PC arithmetic is 32-bit wrap-around; 32'hFFFF_FFFC + 4 = 0. No alignment check.
- Reset asserted mid-request: imem_req drops asynchronously; the memory side must abandon the transaction.

Test Plan:
- Reset then release, memory ready same cycle as req -> imem_addr 0,4,8 on consecutive cycles; inst_valid=1 from 3rd cycle; pc_out=4,8,12 with matching words.
- Memory 3-cycle latency -> imem_addr stable 3 cycles, then one instruction per 3 cycles, no duplicates or drops.
- freeze=1 for 4 cycles while response arrives -> slot holds word A; word B captured in skid with imem_req=0; on freeze release, B appears next cycle, fetch resumes at B+4.
- branch_taken (addr 0x100) while a request to 0x20 is pending -> req stays at 0x20 until ready, data discarded, next request 0x100, inst_valid=0 in between.
- branch_taken and freeze=1 same cycle with skid full -> inst_valid=0 next cycle, skid dropped, next imem_addr=branch_addr.
- rst pulsed low mid-fetch, and pc at 0xFFFF_FFFC -> outputs return to reset values immediately; PC wraps to 0 with pc_out=0.

Source files
------------

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : fetch_stage
// Purpose  : Instruction-fetch stage feeding ID. Owns the PC, issues
//            multi-cycle requests on a req/ready instruction-memory port,
//            and presents {instruction, PC+step} in a one-entry IF/ID slot
//            backed by a one-entry skid buffer. It honours the ID freeze and
//            the EXE branch redirect.
// Ports    : clk, rst (async, active-low)
//            freeze        - ID hazard stall, holds the output slot
//            branch_taken  - one-cycle redirect pulse from EXE
//            branch_addr   - redirect target
//            imem_req/imem_addr/imem_ready/imem_rdata - memory port
//            inst_valid/instruction/pc_out            - IF/ID slot
// Revision : 1.0 - initial release
// ============================================================================
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        freeze,
    input  logic        branch_taken,
    input  logic [31:0] branch_addr,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    output logic [31:0] instruction,
    output logic [31:0] pc_out
);

    // Bit 0 of the encoding is the request line, so imem_req comes
    // straight off a state flop and drops together with the async reset.
    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_REQ    = 2'b01,
        S_HOLD   = 2'b10,
        S_SQUASH = 2'b11
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_req_addr;
    logic [31:0] r_skid_inst;
    logic [31:0] r_skid_pc;
    logic        r_inst_valid;
    logic [31:0] r_instruction;
    logic [31:0] r_pc_out;

    logic        w_slot_free;
    logic        w_consume;
    logic [31:0] w_pc_next;
    logic [31:0] w_req_next;

    assign w_slot_free = !r_inst_valid || !freeze;
    assign w_consume   = r_inst_valid && !freeze;
    assign w_pc_next   = r_pc + PC_STEP;
    assign w_req_next  = r_req_addr + PC_STEP;

    assign imem_req    = r_state[0];
    assign imem_addr   = r_req_addr;
    assign inst_valid  = r_inst_valid;
    assign instruction = r_instruction;
    assign pc_out      = r_pc_out;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= S_IDLE;
            r_pc          <= RESET_PC;
            r_req_addr    <= RESET_PC;
            r_skid_inst   <= 32'd0;
            r_skid_pc     <= 32'd0;
            r_inst_valid  <= 1'b0;
            r_instruction <= 32'd0;
            r_pc_out      <= 32'd0;
        end else begin
            // Slot default: a redirect or a consume empties it. Loads
            // below override this, except when a redirect is present.
            if (branch_taken || w_consume) begin
                r_inst_valid <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    r_state <= S_REQ;
                    if (branch_taken) begin
                        r_pc       <= branch_addr;
                        r_req_addr <= branch_addr;
                    end else begin
                        r_req_addr <= r_pc;
                    end
                end

                // In S_REQ r_pc always equals r_req_addr.
                S_REQ: begin
                    if (imem_ready) begin
                        if (branch_taken) begin
                            r_pc       <= branch_addr;
                            r_req_addr <= branch_addr;
                        end else if (w_slot_free) begin
                            r_instruction <= imem_rdata;
                            r_pc_out      <= w_req_next;
                            r_inst_valid  <= 1'b1;
                            r_pc          <= w_pc_next;
                            r_req_addr    <= w_pc_next;
                        end else begin
                            r_skid_inst <= imem_rdata;
                            r_skid_pc   <= w_req_next;
                            r_pc        <= w_pc_next;
                            r_state     <= S_HOLD;
                        end
                    end else if (branch_taken) begin
                        // The outstanding request cannot be withdrawn; its
                        // response is swallowed in S_SQUASH.
                        r_pc    <= branch_addr;
                        r_state <= S_SQUASH;
                    end
                end

                S_SQUASH: begin
                    if (branch_taken) begin
                        r_pc <= branch_addr;
                    end
                    if (imem_ready) begin
                        r_state    <= S_REQ;
                        r_req_addr <= branch_taken ? branch_addr : r_pc;
                    end
                end

                S_HOLD: begin
                    if (branch_taken) begin
                        r_pc       <= branch_addr;
                        r_req_addr <= branch_addr;
                        r_state    <= S_REQ;
                    end else if (w_consume) begin
                        r_instruction <= r_skid_inst;
                        r_pc_out      <= r_skid_pc;
                        r_inst_valid  <= 1'b1;
                        r_req_addr    <= r_pc;
                        r_state       <= S_REQ;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_fetch_stage
// Purpose  : Directed bench for fetch_stage. Expected fetch addresses are
//            queued by the stimulus; a monitor pops one entry per consumed
//            instruction and compares word and pc_out. A memory model
//            answers requests with a fixed latency and a response budget.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        freeze = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_addr = 32'd0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic [31:0] imem_rdata = 32'd0;
    logic        inst_valid;
    logic [31:0] instruction;
    logic [31:0] pc_out;

    int checks   = 0;
    int failures = 0;
    int mem_lat    = 1;
    int mem_budget = 0;
    int mem_cnt    = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    fetch_stage dut (
        .clk          (clk),
        .rst          (rst),
        .freeze       (freeze),
        .branch_taken (branch_taken),
        .branch_addr  (branch_addr),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ready   (imem_ready),
        .imem_rdata   (imem_rdata),
        .inst_valid   (inst_valid),
        .instruction  (instruction),
        .pc_out       (pc_out)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'hC3A5, a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic to_neg();
        @(negedge clk);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
            exp_q.delete();
        end
        step();
        step();
    endtask

    // Memory model: ready after mem_lat request cycles, while budget lasts.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rst && imem_req && mem_budget > 0) begin
                if (mem_cnt + 1 >= mem_lat) begin
                    imem_ready = 1'b1;
                    imem_rdata = mem_word(imem_addr);
                    mem_cnt    = 0;
                    mem_budget = mem_budget - 1;
                end else begin
                    imem_ready = 1'b0;
                    mem_cnt    = mem_cnt + 1;
                end
            end else begin
                imem_ready = 1'b0;
                mem_cnt    = 0;
            end
        end
    end

    // Monitor: every consumed instruction must match the head of the queue.
    initial begin
        logic [31:0] a;
        forever begin
            @(negedge clk);
            if (rst && inst_valid && !freeze) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_inst: got %h pc_out %h expected none", instruction, pc_out);
                end else begin
                    a = exp_q.pop_front();
                    chk("sb_instruction", instruction, mem_word(a));
                    chk("sb_pc_out", pc_out, a + 32'd4);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values
        repeat (3) step();
        to_neg();
        chk("rst_req", imem_req, 32'd0);
        chk("rst_valid", inst_valid, 32'd0);
        chk("rst_inst", instruction, 32'd0);
        chk("rst_pc_out", pc_out, 32'd0);
        chk("rst_addr", imem_addr, 32'd0);

        // Zero-wait memory: 1 instr/cycle
        step();
        rst = 1'b1; mem_lat = 1; mem_budget = 3;
        exp_q.push_back(32'd0); exp_q.push_back(32'd4); exp_q.push_back(32'd8);
        to_neg();
        chk("idle_req", imem_req, 32'd0);
        step(); to_neg();
        chk("first_req", imem_req, 32'd1);
        chk("first_addr", imem_addr, 32'd0);
        chk("first_valid", inst_valid, 32'd0);
        step(); to_neg();
        chk("b2b_valid", inst_valid, 32'd1);
        chk("b2b_addr1", imem_addr, 32'd4);
        step(); to_neg();
        chk("b2b_addr2", imem_addr, 32'd8);
        drain();

        // Three-cycle latency
        step();
        mem_lat = 3; mem_budget = 2;
        exp_q.push_back(32'd12); exp_q.push_back(32'd16);
        step(); to_neg(); chk("lat_addr_c1", imem_addr, 32'd12);
        step(); to_neg(); chk("lat_addr_c2", imem_addr, 32'd12);
        step(); to_neg(); chk("lat_addr_c3", imem_addr, 32'd12);
        chk("lat_valid_c3", inst_valid, 32'd0);
        step(); to_neg();
        chk("lat_next_addr", imem_addr, 32'd16);
        chk("lat_valid", inst_valid, 32'd1);
        drain();

        // Freeze for 4 cycles: A held in slot, B in skid
        step();
        freeze = 1'b1; mem_lat = 1; mem_budget = 2;
        exp_q.push_back(32'd20); exp_q.push_back(32'd24);
        step(); step(); step(); to_neg();
        chk("hold_req", imem_req, 32'd0);
        chk("hold_valid", inst_valid, 32'd1);
        chk("hold_slot_word", instruction, mem_word(32'd20));
        step();
        freeze = 1'b0;
        to_neg();
        chk("hold_req_release", imem_req, 32'd0);
        step(); to_neg();
        chk("resume_addr", imem_addr, 32'd28);
        chk("resume_req", imem_req, 32'd1);
        drain();

        // Branch while request to 0x20 is pending
        step();
        mem_lat = 1; mem_budget = 1;
        exp_q.push_back(32'd28);
        step(); step();
        mem_lat = 3; mem_budget = 2; branch_taken = 1'b1; branch_addr = 32'h100;
        exp_q.push_back(32'h100);
        step();
        branch_taken = 1'b0;
        to_neg();
        chk("sq_addr_c1", imem_addr, 32'h20);
        chk("sq_req_c1", imem_req, 32'd1);
        chk("sq_valid_c1", inst_valid, 32'd0);
        step(); to_neg();
        chk("sq_addr_c2", imem_addr, 32'h20);
        chk("sq_valid_c2", inst_valid, 32'd0);
        step(); to_neg();
        chk("sq_addr_c3", imem_addr, 32'h20);
        chk("sq_valid_c3", inst_valid, 32'd0);
        step(); to_neg();
        chk("sq_target_addr", imem_addr, 32'h100);
        chk("sq_valid_c4", inst_valid, 32'd0);
        drain();

        // Branch with freeze and full skid
        step();
        freeze = 1'b1; mem_lat = 1; mem_budget = 2;
        step(); step(); step(); to_neg();
        chk("bf_skid_full_req", imem_req, 32'd0);
        step();
        branch_taken = 1'b1; branch_addr = 32'h200;
        step();
        branch_taken = 1'b0;
        to_neg();
        chk("bf_valid", inst_valid, 32'd0);
        chk("bf_addr", imem_addr, 32'h200);
        chk("bf_req", imem_req, 32'd1);
        step();
        freeze = 1'b0; mem_budget = 1;
        exp_q.push_back(32'h200);
        drain();

        // PC wrap-around
        step();
        branch_taken = 1'b1; branch_addr = 32'hFFFF_FFFC;
        step();
        branch_taken = 1'b0; mem_lat = 1; mem_budget = 3;
        exp_q.push_back(32'hFFFF_FFFC); exp_q.push_back(32'h0);
        step(); step(); to_neg();
        chk("wrap_top_addr", imem_addr, 32'hFFFF_FFFC);
        step(); to_neg();
        chk("wrap_addr", imem_addr, 32'h0);
        drain();

        // Reset asserted mid-request
        step();
        freeze = 1'b1; mem_lat = 1; mem_budget = 1;
        step(); step();
        mem_lat = 3; mem_budget = 1;
        step(); step();
        chk("pre_rst_valid", inst_valid, 32'd1);
        chk("pre_rst_req", imem_req, 32'd1);
        #1;
        rst = 1'b0; mem_budget = 0;
        #1;
        chk("async_rst_req", imem_req, 32'd0);
        chk("async_rst_valid", inst_valid, 32'd0);
        chk("async_rst_inst", instruction, 32'd0);
        chk("async_rst_pc_out", pc_out, 32'd0);
        chk("async_rst_addr", imem_addr, 32'd0);
        step();
        freeze = 1'b0; rst = 1'b1; mem_lat = 1; mem_budget = 1;
        exp_q.push_back(32'd0);
        to_neg();
        chk("rerst_idle_req", imem_req, 32'd0);
        step(); to_neg();
        chk("rerst_addr", imem_addr, 32'd0);
        chk("rerst_req", imem_req, 32'd1);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
